dcache_write_buffer: RTL and testbench

DCACHE_WRITE_BUFFER -- requirements
Module: dcache_write_buffer

---
 rtl/dcache_write_buffer_pkg.sv | 20 ++
 rtl/dcache_write_buffer_wb_lookup.sv | 33 +++
 rtl/dcache_write_buffer.sv | 125 ++++++++++++
 tb/tb_dcache_write_buffer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dcache_write_buffer_pkg.sv
// Shared widths, entry flag encodings and drain FSM states for the DCache write buffer.
package dcache_write_buffer_pkg;
  localparam int WB_DEPTH_DEF = 4;
  localparam int ADDR_W       = 32;
  localparam int LINE_W       = 256;
  localparam int OFS_W        = 5;
  localparam int TAG_W        = ADDR_W - OFS_W;

  localparam logic ENTRY_VALID   = 1'b1;
  localparam logic ENTRY_INVALID = 1'b0;

  typedef enum logic {
    DRAIN_IDLE = 1'b0,
    DRAIN_BUSY = 1'b1
  } drain_state_t;

  function automatic logic [TAG_W-1:0] line_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:OFS_W];
  endfunction
endpackage

// File: rtl/dcache_write_buffer_wb_lookup.sv
// Parallel tag compare over all entries; among several matches the youngest (furthest from head) wins.
module wb_lookup
  import dcache_write_buffer_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEF,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] valid,
  input  logic [TAG_W-1:0] tags [DEPTH],
  input  logic [PTR_W-1:0] head,
  input  logic [DEPTH-1:0] excl,
  input  logic [TAG_W-1:0] key,
  output logic             hit,
  output logic [PTR_W-1:0] idx
);
  logic [PTR_W-1:0] age;
  logic [PTR_W-1:0] best_age;

  always_comb begin
    hit      = 1'b0;
    idx      = '0;
    age      = '0;
    best_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age = PTR_W'(i) - head;
      if (valid[i] && !excl[i] && (tags[i] == key) && (!hit || (age >= best_age))) begin
        hit      = 1'b1;
        idx      = PTR_W'(i);
        best_age = age;
      end
    end
  end
endmodule

// File: rtl/dcache_write_buffer.sv
// Coalescing circular write buffer between DCache and the downstream write port.
// Lines drain from the head one at a time; queued lines are visible to miss lookups.
module dcache_write_buffer
  import dcache_write_buffer_pkg::*;
#(
  parameter int WB_DEPTH = WB_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wb_wen_i,
  input  logic [ADDR_W-1:0]            wb_waddr_i,
  input  logic [LINE_W-1:0]            wb_wdata_i,
  output logic                         wb_full_o,
  output logic                         wb_empty_o,
  input  logic [ADDR_W-1:0]            lk_addr_i,
  output logic                         lk_hit_o,
  output logic [LINE_W-1:0]            lk_data_o,
  output logic                         mem_wen_o,
  output logic [ADDR_W-1:0]            mem_waddr_o,
  output logic [LINE_W-1:0]            mem_wdata_o,
  input  logic                         mem_bvalid_i,
  output drain_state_t                 dbg_state,
  output logic [$clog2(WB_DEPTH):0]    dbg_count
);
  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WB_DEPTH-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q  [WB_DEPTH];
  logic [LINE_W-1:0]   data_q [WB_DEPTH];
  logic [PTR_W-1:0]    head_q, tail_q;
  logic [CNT_W-1:0]    count_q;
  drain_state_t        state_q;
  logic                mem_wen_q;

  logic                co_hit, lk_hit;
  logic [PTR_W-1:0]    co_idx, lk_idx;
  logic [WB_DEPTH-1:0] inflight_mask;
  logic                push_ok, do_coal, do_alloc, do_pop;

  // The in-flight head must never be rewritten, so it is hidden from the coalesce search.
  assign inflight_mask = (state_q == DRAIN_BUSY) ? (WB_DEPTH'(1) << head_q) : '0;

  wb_lookup #(.DEPTH(WB_DEPTH), .PTR_W(PTR_W)) u_coalesce (
    .valid (valid_q),
    .tags  (tag_q),
    .head  (head_q),
    .excl  (inflight_mask),
    .key   (line_tag(wb_waddr_i)),
    .hit   (co_hit),
    .idx   (co_idx)
  );

  wb_lookup #(.DEPTH(WB_DEPTH), .PTR_W(PTR_W)) u_lookup (
    .valid (valid_q),
    .tags  (tag_q),
    .head  (head_q),
    .excl  ('0),
    .key   (line_tag(lk_addr_i)),
    .hit   (lk_hit),
    .idx   (lk_idx)
  );

  // Handshakes: a push is taken when wb_wen_i && !wb_full_o. Downstream, mem_wen_o is held
  // with stable address/data until a one-cycle mem_bvalid_i retires the head entry.
  assign wb_full_o = (count_q == CNT_W'(WB_DEPTH));
  assign push_ok   = wb_wen_i && !wb_full_o;
  assign do_coal   = push_ok && co_hit;
  assign do_alloc  = push_ok && !co_hit;
  assign do_pop    = (state_q == DRAIN_BUSY) && mem_bvalid_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      state_q   <= DRAIN_IDLE;
      mem_wen_q <= 1'b0;
    end else begin
      if (do_pop) begin
        valid_q[head_q] <= ENTRY_INVALID;
        head_q          <= head_q + PTR_W'(1);
      end
      if (do_alloc) begin
        valid_q[tail_q] <= ENTRY_VALID;
        tail_q          <= tail_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(do_alloc) - CNT_W'(do_pop);
      unique case (state_q)
        DRAIN_IDLE: if (count_q != '0) begin
          state_q   <= DRAIN_BUSY;
          mem_wen_q <= 1'b1;
        end
        DRAIN_BUSY: if (mem_bvalid_i) begin
          state_q   <= DRAIN_IDLE;
          mem_wen_q <= 1'b0;
        end
        default: begin
          state_q   <= DRAIN_IDLE;
          mem_wen_q <= 1'b0;
        end
      endcase
    end
  end

  // Payload storage carries no reset; valid_q qualifies every read.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      tag_q[tail_q]  <= line_tag(wb_waddr_i);
      data_q[tail_q] <= wb_wdata_i;
    end else if (do_coal) begin
      data_q[co_idx] <= wb_wdata_i;
    end
  end

  assign wb_empty_o  = (count_q == '0) && (state_q == DRAIN_IDLE);
  assign mem_wen_o   = mem_wen_q;
  assign mem_waddr_o = {tag_q[head_q], {OFS_W{1'b0}}};
  assign mem_wdata_o = data_q[head_q];
  assign lk_hit_o    = lk_hit;
  assign lk_data_o   = lk_hit ? data_q[lk_idx] : '0;
  assign dbg_state   = state_q;
  assign dbg_count   = count_q;
endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed bench for dcache_write_buffer: drain, full, coalesce, lookup, push/pop overlap, reset.
module tb_dcache_write_buffer;
  import dcache_write_buffer_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         wb_wen_i;
  logic [31:0]  wb_waddr_i;
  logic [255:0] wb_wdata_i;
  logic         wb_full_o, wb_empty_o;
  logic [31:0]  lk_addr_i;
  logic         lk_hit_o;
  logic [255:0] lk_data_o;
  logic         mem_wen_o;
  logic [31:0]  mem_waddr_o;
  logic [255:0] mem_wdata_o;
  logic         mem_bvalid_i;
  drain_state_t dbg_state;
  logic [2:0]   dbg_count;

  int checks = 0;
  int failures = 0;
  logic [31:0]  exp_addr_q[$];
  logic [255:0] exp_data_q[$];

  dcache_write_buffer #(.WB_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .wb_wen_i(wb_wen_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
    .wb_full_o(wb_full_o), .wb_empty_o(wb_empty_o),
    .lk_addr_i(lk_addr_i), .lk_hit_o(lk_hit_o), .lk_data_o(lk_data_o),
    .mem_wen_o(mem_wen_o), .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o),
    .mem_bvalid_i(mem_bvalid_i), .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] mk_line(input logic [31:0] seed);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = seed + 32'(i);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [255:0] d);
    wb_wen_i = 1'b1; wb_waddr_i = a; wb_wdata_i = d;
    tick();
    wb_wen_i = 1'b0;
  endtask

  // Acknowledges every downstream write and checks it against the expected queue.
  task automatic drain_all(input string name);
    int k;
    k = 0;
    while (!wb_empty_o && k < 200) begin
      if (mem_wen_o) begin
        checks++;
        if (exp_addr_q.size() == 0) begin
          failures++; $display("FAIL %s_extra_write got addr=%h exp none", name, mem_waddr_o);
        end else begin
          if (mem_waddr_o !== exp_addr_q[0] || mem_wdata_o !== exp_data_q[0]) begin
            failures++; $display("FAIL %s_write got addr=%h data0=%h exp addr=%h data0=%h", name, mem_waddr_o, mem_wdata_o[31:0], exp_addr_q[0], exp_data_q[0][31:0]);
          end
          void'(exp_addr_q.pop_front());
          void'(exp_data_q.pop_front());
        end
        mem_bvalid_i = 1'b1;
      end else begin
        mem_bvalid_i = 1'b0;
      end
      tick();
      k++;
    end
    mem_bvalid_i = 1'b0;
    checks++;
    if (!wb_empty_o || exp_addr_q.size() != 0) begin
      failures++; $display("FAIL %s_drain got empty=%b left=%0d exp empty=1 left=0", name, wb_empty_o, exp_addr_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    lk_addr_i = 32'h0000_1020;
    #1;
    checks++; if (mem_wen_o !== 1'b0) begin failures++; $display("FAIL reset_mem_wen got=%b exp=0", mem_wen_o); end
    checks++; if (wb_full_o !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", wb_full_o); end
    checks++; if (wb_empty_o !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", wb_empty_o); end
    checks++; if (lk_hit_o !== 1'b0 || lk_data_o !== '0) begin failures++; $display("FAIL reset_lookup got hit=%b exp hit=0 data=0", lk_hit_o); end
    checks++; if (dbg_count !== 3'd0 || dbg_state !== DRAIN_IDLE) begin failures++; $display("FAIL reset_state got count=%0d state=%0d exp 0 0", dbg_count, dbg_state); end
  endtask

  task automatic test_single();
    logic [255:0] d1;
    d1 = mk_line(32'hD100_0000);
    push(32'h0000_1020, d1);
    checks++; if (dbg_count !== 3'd1 || mem_wen_o !== 1'b0 || wb_empty_o !== 1'b0) begin failures++; $display("FAIL single_queued got count=%0d wen=%b empty=%b exp 1 0 0", dbg_count, mem_wen_o, wb_empty_o); end
    lk_addr_i = 32'h0000_1024; #1;
    checks++; if (lk_hit_o !== 1'b1 || lk_data_o !== d1) begin failures++; $display("FAIL lookup_hit got hit=%b data0=%h exp hit=1 data0=%h", lk_hit_o, lk_data_o[31:0], d1[31:0]); end
    lk_addr_i = 32'h0000_2000; #1;
    checks++; if (lk_hit_o !== 1'b0 || lk_data_o !== '0) begin failures++; $display("FAIL lookup_miss got hit=%b data0=%h exp hit=0 data=0", lk_hit_o, lk_data_o[31:0]); end
    mem_bvalid_i = 1'b1;
    tick();
    mem_bvalid_i = 1'b0;
    checks++; if (dbg_count !== 3'd1 || mem_wen_o !== 1'b1) begin failures++; $display("FAIL idle_bvalid_ignored got count=%0d wen=%b exp 1 1", dbg_count, mem_wen_o); end
    checks++; if (mem_waddr_o !== 32'h0000_1020 || mem_wdata_o !== d1) begin failures++; $display("FAIL single_mem got addr=%h exp=00001020", mem_waddr_o); end
    tick(); tick();
    checks++; if (mem_wen_o !== 1'b1 || mem_waddr_o !== 32'h0000_1020) begin failures++; $display("FAIL single_hold got wen=%b addr=%h exp 1 00001020", mem_wen_o, mem_waddr_o); end
    mem_bvalid_i = 1'b1;
    lk_addr_i = 32'h0000_1020; #1;
    checks++; if (lk_hit_o !== 1'b1) begin failures++; $display("FAIL pop_cycle_hit got=%b exp=1", lk_hit_o); end
    tick();
    mem_bvalid_i = 1'b0;
    checks++; if (mem_wen_o !== 1'b0 || wb_empty_o !== 1'b1 || dbg_count !== 3'd0) begin failures++; $display("FAIL single_popped got wen=%b empty=%b count=%0d exp 0 1 0", mem_wen_o, wb_empty_o, dbg_count); end
    checks++; if (lk_hit_o !== 1'b0 || lk_data_o !== '0) begin failures++; $display("FAIL popped_lookup got hit=%b exp=0", lk_hit_o); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      checks++; if (wb_full_o !== 1'b0) begin failures++; $display("FAIL full_early_%0d got=1 exp=0", i); end
      push(32'h0000_2000 + 32'(i * 32) + 32'((i + 1) * 3), mk_line(32'h2000_0000 + 32'(i << 8)));
      exp_addr_q.push_back(32'h0000_2000 + 32'(i * 32));
      exp_data_q.push_back(mk_line(32'h2000_0000 + 32'(i << 8)));
    end
    checks++; if (wb_full_o !== 1'b1 || dbg_count !== 3'd4) begin failures++; $display("FAIL full_set got full=%b count=%0d exp 1 4", wb_full_o, dbg_count); end
    wb_wen_i = 1'b1; wb_waddr_i = 32'h0000_2080; wb_wdata_i = mk_line(32'h2080_0000); #1;
    checks++; if (wb_full_o !== 1'b1) begin failures++; $display("FAIL full_with_wen got=%b exp=1", wb_full_o); end
    tick();
    wb_wen_i = 1'b0;
    lk_addr_i = 32'h0000_2080; #1;
    checks++; if (dbg_count !== 3'd4 || lk_hit_o !== 1'b0) begin failures++; $display("FAIL full_push_ignored got count=%0d hit=%b exp 4 0", dbg_count, lk_hit_o); end
    checks++; if (mem_wen_o !== 1'b1 || mem_waddr_o !== 32'h0000_2000) begin failures++; $display("FAIL full_head got wen=%b addr=%h exp 1 00002000", mem_wen_o, mem_waddr_o); end
    void'(exp_addr_q.pop_front());
    void'(exp_data_q.pop_front());
    mem_bvalid_i = 1'b1;
    tick();
    mem_bvalid_i = 1'b0;
    checks++; if (wb_full_o !== 1'b0 || dbg_count !== 3'd3) begin failures++; $display("FAIL full_cleared got full=%b count=%0d exp 0 3", wb_full_o, dbg_count); end
    drain_all("full");
  endtask

  task automatic test_coalesce();
    push(32'h0000_3000, mk_line(32'hA000_0000));
    push(32'h0000_3020, mk_line(32'hB000_0000));
    checks++; if (mem_wen_o !== 1'b1 || mem_waddr_o !== 32'h0000_3000) begin failures++; $display("FAIL coal_inflight got wen=%b addr=%h exp 1 00003000", mem_wen_o, mem_waddr_o); end
    push(32'h0000_3020, mk_line(32'hB200_0000));
    lk_addr_i = 32'h0000_3020; #1;
    checks++; if (dbg_count !== 3'd2 || lk_data_o !== mk_line(32'hB200_0000)) begin failures++; $display("FAIL coal_merge got count=%0d data0=%h exp 2 b2000000", dbg_count, lk_data_o[31:0]); end
    push(32'h0000_3000, mk_line(32'hA200_0000));
    lk_addr_i = 32'h0000_3000; #1;
    checks++; if (dbg_count !== 3'd3 || mem_wdata_o !== mk_line(32'hA000_0000)) begin failures++; $display("FAIL coal_head_kept got count=%0d data0=%h exp 3 a0000000", dbg_count, mem_wdata_o[31:0]); end
    checks++; if (lk_hit_o !== 1'b1 || lk_data_o !== mk_line(32'hA200_0000)) begin failures++; $display("FAIL lookup_youngest got data0=%h exp a2000000", lk_data_o[31:0]); end
    exp_addr_q.push_back(32'h0000_3000); exp_data_q.push_back(mk_line(32'hA000_0000));
    exp_addr_q.push_back(32'h0000_3020); exp_data_q.push_back(mk_line(32'hB200_0000));
    exp_addr_q.push_back(32'h0000_3000); exp_data_q.push_back(mk_line(32'hA200_0000));
    drain_all("coalesce");
  endtask

  task automatic test_pop_push();
    for (int i = 0; i < 4; i++) push(32'h0000_4000 + 32'(i * 32), mk_line(32'h4000_0000 + 32'(i << 8)));
    wb_wen_i = 1'b1; wb_waddr_i = 32'h0000_4080; wb_wdata_i = mk_line(32'h4080_0000);
    mem_bvalid_i = 1'b1;
    tick();
    wb_wen_i = 1'b0; mem_bvalid_i = 1'b0;
    lk_addr_i = 32'h0000_4080; #1;
    checks++; if (dbg_count !== 3'd3 || wb_full_o !== 1'b0 || lk_hit_o !== 1'b0) begin failures++; $display("FAIL full_pop_push got count=%0d full=%b hit=%b exp 3 0 0", dbg_count, wb_full_o, lk_hit_o); end
    tick();
    checks++; if (mem_wen_o !== 1'b1 || mem_waddr_o !== 32'h0000_4020) begin failures++; $display("FAIL pop_next_head got wen=%b addr=%h exp 1 00004020", mem_wen_o, mem_waddr_o); end
    mem_bvalid_i = 1'b1;
    tick();
    mem_bvalid_i = 1'b0;
    tick();
    wb_wen_i = 1'b1; wb_waddr_i = 32'h0000_40A0; wb_wdata_i = mk_line(32'h40A0_0000);
    mem_bvalid_i = 1'b1;
    tick();
    wb_wen_i = 1'b0; mem_bvalid_i = 1'b0;
    lk_addr_i = 32'h0000_4040; #1;
    checks++; if (dbg_count !== 3'd2 || lk_hit_o !== 1'b0) begin failures++; $display("FAIL pop_push_count got count=%0d hit=%b exp 2 0", dbg_count, lk_hit_o); end
    exp_addr_q.push_back(32'h0000_4060); exp_data_q.push_back(mk_line(32'h4000_0300));
    exp_addr_q.push_back(32'h0000_40A0); exp_data_q.push_back(mk_line(32'h40A0_0000));
    drain_all("pop_push");
  endtask

  task automatic test_reset_mid_drain();
    push(32'h0000_5013, mk_line(32'h5000_0000));
    push(32'h0000_5020, mk_line(32'h5020_0000));
    push(32'h0000_5040, mk_line(32'h5040_0000));
    lk_addr_i = 32'h0000_5000; #1;
    checks++; if (mem_wen_o !== 1'b1 || dbg_count !== 3'd3 || lk_hit_o !== 1'b1 || mem_waddr_o !== 32'h0000_5000) begin failures++; $display("FAIL mid_drain_pre got wen=%b count=%0d hit=%b addr=%h exp 1 3 1 00005000", mem_wen_o, dbg_count, lk_hit_o, mem_waddr_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    checks++; if (mem_wen_o !== 1'b0 || wb_empty_o !== 1'b1 || dbg_count !== 3'd0 || lk_hit_o !== 1'b0) begin failures++; $display("FAIL mid_drain_reset got wen=%b empty=%b count=%0d hit=%b exp 0 1 0 0", mem_wen_o, wb_empty_o, dbg_count, lk_hit_o); end
    mem_bvalid_i = 1'b1;
    tick();
    mem_bvalid_i = 1'b0;
    checks++; if (mem_wen_o !== 1'b0 || wb_empty_o !== 1'b1 || dbg_count !== 3'd0 || dbg_state !== DRAIN_IDLE) begin failures++; $display("FAIL late_bvalid got wen=%b empty=%b count=%0d exp 0 1 0", mem_wen_o, wb_empty_o, dbg_count); end
  endtask

  initial begin
    rst = 1'b1; wb_wen_i = 1'b0; wb_waddr_i = '0; wb_wdata_i = '0;
    lk_addr_i = '0; mem_bvalid_i = 1'b0;
    test_reset();
    test_single();
    test_full();
    test_coalesce();
    test_pop_push();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
